// File: rtl/counter_seq_ctrl.sv
// counter_seq_ctrl: sequencing controller for one 4-bit Upcounter.
// It clears the counter, counts it up to a latched target, and checks
// the counter output against a shadow count.
module counter_seq_ctrl #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] target,
  input  logic             hold,
  input  logic             abort,
  input  logic [WIDTH-1:0] counter_in,
  output logic             cnt_reset,
  output logic             cnt_enable,
  output logic             busy,
  output logic             done,
  output logic             err
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    RUN   = 3'd2,
    DONE  = 3'd3,
    ERR   = 3'd4
  } state_t;

  state_t           state;
  state_t           state_d;
  logic [WIDTH-1:0] tgt_q;
  logic [WIDTH-1:0] exp_q;

  // Counter enable: only in RUN, gated by hold/abort, stops at the target.
  always_comb begin
    cnt_enable = (state == RUN) && !abort && !hold && (counter_in != tgt_q);
  end

  // Next-state selection; abort overrides everything outside IDLE.
  always_comb begin
    state_d = state;
    unique case (state)
      IDLE:    if (start) state_d = CLEAR;
      CLEAR:   state_d = RUN;
      RUN: begin
        if (counter_in != exp_q)      state_d = ERR;
        else if (counter_in == tgt_q) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      ERR:     state_d = ERR;
      default: state_d = IDLE;
    endcase
    if (abort && (state != IDLE)) state_d = IDLE;
  end

  // State, target/shadow registers, and state-decoded outputs. The decodes
  // are registered from the next state so they align with the state itself.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      tgt_q     <= '0;
      exp_q     <= '0;
      cnt_reset <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state <= state_d;
      if ((state == IDLE) && start) tgt_q <= target;
      if (state == CLEAR)   exp_q <= '0;
      else if (cnt_enable)  exp_q <= exp_q + WIDTH'(1);
      cnt_reset <= (state_d == CLEAR);
      done      <= (state_d == DONE);
      err       <= (state_d == ERR);
      busy      <= (state_d != IDLE);
    end
  end

endmodule
